multi_ready_ctrl: RTL and testbench

Parametrised N-player lobby and round controller for the factorization game. It collects per-player ready presses, runs a cancellable start countdown, and tracks per-player HP from judged answers. It declares a winner or a draw. It sits between the player button inputs and the question/judge logic, and it drives the per-player lamps and the countdown digit.

---
 rtl/multi_ready_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_multi_ready_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ready_ctrl.sv
// rtl/multi_ready_ctrl.sv - N-player lobby, start countdown and HP round controller
// Ready presses fill the lobby, a cancellable countdown starts play, judged answers drain HP.
module multi_ready_ctrl #(
  parameter int N_PLAYER    = 2,
  parameter int HP_INIT     = 3,
  parameter int HP_W        = 2,
  parameter int COUNT_START = 9,
  parameter int TICK_DIV    = 50_000_000,
  parameter int PW          = (N_PLAYER > 2) ? $clog2(N_PLAYER) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_PLAYER-1:0]      ready_i,
  input  logic                     ans_valid_i,
  input  logic [PW-1:0]            ans_player_i,
  input  logic                     ans_ok_i,
  output logic [3:0]               state_o,
  output logic [3:0]               num_o,
  output logic [N_PLAYER-1:0]      led_o,
  output logic [N_PLAYER*HP_W-1:0] hp_o,
  output logic [N_PLAYER-1:0]      alive_o,
  output logic                     go_o,
  output logic                     win_valid_o,
  output logic                     draw_o,
  output logic [PW-1:0]            winner_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    S_LOBBY  = 4'd0,
    S_COUNT  = 4'd1,
    S_PLAY   = 4'd2,
    S_RESULT = 4'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 num_q, num_d;
  logic [TW-1:0]              tick_q, tick_d;
  logic [N_PLAYER-1:0]        flags_q, flags_d;
  logic [N_PLAYER-1:0]        prev_q, prev_d;
  logic [N_PLAYER-1:0]        led_q, led_d;
  logic [N_PLAYER*HP_W-1:0]   hp_q, hp_d;
  logic                       go_q, go_d;
  logic                       win_valid_q, win_valid_d;
  logic                       draw_q, draw_d;
  logic [PW-1:0]              winner_q, winner_d;

  logic [N_PLAYER-1:0]        press;
  logic [N_PLAYER-1:0]        alive_cur;
  logic [N_PLAYER-1:0]        alive_nxt;
  logic                       sel_alive;
  logic [HP_W-1:0]            fld;
  logic [3:0]                 n_alive;
  logic [PW-1:0]              last_idx;

  assign press = ready_i & ~prev_q;

  always_comb begin
    alive_cur = '0;
    for (int i = 0; i < N_PLAYER; i++) begin
      alive_cur[i] = |hp_q[i*HP_W +: HP_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_LOBBY;
      num_q       <= '0;
      tick_q      <= '0;
      flags_q     <= '0;
      prev_q      <= '1;
      led_q       <= '0;
      hp_q        <= {N_PLAYER{HP_W'(HP_INIT)}};
      go_q        <= 1'b0;
      win_valid_q <= 1'b0;
      draw_q      <= 1'b0;
      winner_q    <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      tick_q      <= tick_d;
      flags_q     <= flags_d;
      prev_q      <= prev_d;
      led_q       <= led_d;
      hp_q        <= hp_d;
      go_q        <= go_d;
      win_valid_q <= win_valid_d;
      draw_q      <= draw_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    tick_d      = tick_q;
    flags_d     = flags_q;
    prev_d      = ready_i;
    hp_d        = hp_q;
    go_d        = 1'b0;
    win_valid_d = win_valid_q;
    draw_d      = draw_q;
    winner_d    = winner_q;
    sel_alive   = 1'b0;
    fld         = '0;
    n_alive     = '0;
    last_idx    = '0;
    alive_nxt   = '0;
    led_d       = '0;

    case (state_q)
      S_LOBBY: begin
        if (&flags_q) begin
          state_d = S_COUNT;
          num_d   = 4'(COUNT_START);
          tick_d  = '0;
        end else begin
          flags_d = flags_q ^ press;
        end
      end
      S_COUNT: begin
        // An abort wins over a tick wrap landing in the same cycle.
        if (|press) begin
          flags_d = flags_q & ~press;
          state_d = S_LOBBY;
          num_d   = '0;
          tick_d  = '0;
        end else if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (num_q != 4'd0) begin
            num_d = num_q - 4'd1;
          end else begin
            state_d = S_PLAY;
            go_d    = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_PLAY: begin
        // Out-of-range indices never match the loop, so they stay unselected.
        for (int i = 0; i < N_PLAYER; i++) begin
          if (PW'(i) == ans_player_i) sel_alive = alive_cur[i];
        end
        if (ans_valid_i && sel_alive) begin
          for (int i = 0; i < N_PLAYER; i++) begin
            fld = hp_q[i*HP_W +: HP_W];
            if (((PW'(i) == ans_player_i) != ans_ok_i) && (fld != '0)) begin
              hp_d[i*HP_W +: HP_W] = fld - HP_W'(1);
            end
          end
        end
      end
      S_RESULT: begin
        if (|press) begin
          state_d     = S_LOBBY;
          flags_d     = '0;
          hp_d        = {N_PLAYER{HP_W'(HP_INIT)}};
          win_valid_d = 1'b0;
          draw_d      = 1'b0;
          winner_d    = '0;
        end
      end
      default: state_d = S_LOBBY;
    endcase

    for (int i = 0; i < N_PLAYER; i++) begin
      alive_nxt[i] = |hp_d[i*HP_W +: HP_W];
      if (alive_nxt[i]) begin
        n_alive  = n_alive + 4'd1;
        last_idx = PW'(i);
      end
    end

    if (state_q == S_PLAY) begin
      if (n_alive == 4'd1) begin
        state_d     = S_RESULT;
        win_valid_d = 1'b1;
        draw_d      = 1'b0;
        winner_d    = last_idx;
      end else if (n_alive == 4'd0) begin
        state_d     = S_RESULT;
        win_valid_d = 1'b1;
        draw_d      = 1'b1;
        winner_d    = '0;
      end
    end

    // Lamps follow the state being entered so they line up with STATE.
    case (state_d)
      S_LOBBY, S_COUNT: led_d = flags_d;
      S_PLAY:           led_d = alive_nxt;
      default: begin
        for (int i = 0; i < N_PLAYER; i++) begin
          led_d[i] = !draw_d && (PW'(i) == winner_d);
        end
      end
    endcase
  end

  always_comb begin
    state_o     = state_q;
    num_o       = num_q;
    led_o       = led_q;
    hp_o        = hp_q;
    alive_o     = alive_cur;
    go_o        = go_q;
    win_valid_o = win_valid_q;
    draw_o      = draw_q;
    winner_o    = winner_q;
  end

endmodule

// File: tb/tb_multi_ready_ctrl.sv
// tb/tb_multi_ready_ctrl.sv - directed bench with a cycle model for multi_ready_ctrl
module tb_multi_ready_ctrl;
  localparam int N  = 3;
  localparam int HI = 2;
  localparam int CS = 3;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ready = 3'b111;
  logic       ans_valid = 1'b0;
  logic [1:0] ans_player = 2'd0;
  logic       ans_ok = 1'b0;
  logic [3:0] state_o, num_o;
  logic [2:0] led_o, alive_o;
  logic [5:0] hp_o;
  logic       go_o, win_valid_o, draw_o;
  logic [1:0] winner_o;

  int n_checks = 0;
  int n_pass   = 0;

  multi_ready_ctrl #(
    .N_PLAYER(N), .HP_INIT(HI), .HP_W(2), .COUNT_START(CS), .TICK_DIV(TD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ready_i(ready), .ans_valid_i(ans_valid),
    .ans_player_i(ans_player), .ans_ok_i(ans_ok), .state_o(state_o), .num_o(num_o),
    .led_o(led_o), .hp_o(hp_o), .alive_o(alive_o), .go_o(go_o),
    .win_valid_o(win_valid_o), .draw_o(draw_o), .winner_o(winner_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: phase, elapsed countdown time and integer HP per player.
  int   m_state = 0;
  int   m_elapsed = 0;
  int   m_hp[N];
  int   m_winner = 0;
  bit   m_draw = 0;
  bit   m_go = 0;
  bit   m_valid = 0;
  logic [2:0] m_flags = '0;
  logic [2:0] m_prev = '1;

  always @(posedge clk) begin
    logic [2:0] pr;
    int p, alive_n, last;
    if (rst) begin
      m_state = 0; m_elapsed = 0; m_flags = '0; m_prev = '1;
      for (int i = 0; i < N; i++) m_hp[i] = HI;
      m_go = 0; m_winner = 0; m_draw = 0; m_valid = 1;
    end else begin
      pr = ready & ~m_prev;
      m_prev = ready;
      m_go = 0;
      case (m_state)
        0: if (m_flags == 3'b111) begin m_state = 1; m_elapsed = 0; end
           else m_flags = m_flags ^ pr;
        1: if (pr != 0) begin m_flags = m_flags & ~pr; m_state = 0; end
           else begin
             m_elapsed++;
             if (m_elapsed == (CS + 1) * TD) begin m_state = 2; m_go = 1; end
           end
        2: begin
          p = int'(ans_player);
          if (ans_valid && p < N && m_hp[p] > 0) begin
            for (int i = 0; i < N; i++) begin
              if (ans_ok ? (i != p) : (i == p)) m_hp[i] = (m_hp[i] > 0) ? m_hp[i] - 1 : 0;
            end
          end
          alive_n = 0; last = 0;
          for (int i = 0; i < N; i++) if (m_hp[i] > 0) begin alive_n++; last = i; end
          if (alive_n == 1) begin m_state = 3; m_winner = last; m_draw = 0; end
          else if (alive_n == 0) begin m_state = 3; m_winner = 0; m_draw = 1; end
        end
        default: if (pr != 0) begin
          m_state = 0; m_flags = '0; m_winner = 0; m_draw = 0;
          for (int i = 0; i < N; i++) m_hp[i] = HI;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [5:0] e_hp;
    logic [2:0] e_alive, e_led;
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        e_hp[i*2 +: 2] = 2'(m_hp[i]);
        e_alive[i] = (m_hp[i] != 0);
      end
      case (m_state)
        0, 1:    e_led = m_flags;
        2:       e_led = e_alive;
        default: e_led = m_draw ? 3'b000 : 3'(1 << m_winner);
      endcase
      check("m_state", 32'(state_o), 32'(m_state));
      check("m_num", 32'(num_o), (m_state == 1) ? 32'(CS - m_elapsed / TD) : 32'd0);
      check("m_led", 32'(led_o), 32'(e_led));
      check("m_hp", 32'(hp_o), 32'(e_hp));
      check("m_alive", 32'(alive_o), 32'(e_alive));
      check("m_go", 32'(go_o), 32'(m_go));
      check("m_win_valid", 32'(win_valid_o), 32'(m_state == 3));
      check("m_draw", 32'(draw_o), 32'(m_state == 3 && m_draw));
      check("m_winner", 32'(winner_o), (m_state == 3) ? 32'(m_winner) : 32'd0);
    end
  end

  task automatic press(input int i);
    @(negedge clk); ready[i] = 1'b1;
    @(negedge clk); ready[i] = 1'b0;
  endtask

  task automatic press_all();
    press(0); press(1); press(2);
  endtask

  task automatic ans(input int p, input bit ok);
    @(negedge clk); ans_valid = 1'b1; ans_player = 2'(p); ans_ok = ok;
  endtask

  task automatic ans_idle();
    @(negedge clk); ans_valid = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int c = 0; c < budget && int'(state_o) != s; c++) @(negedge clk);
    check("wait_state", 32'(state_o), 32'(s));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("held_led", 32'(led_o), 32'h0);
    check("held_hp", 32'(hp_o), 32'h2A);
    check("held_alive", 32'(alive_o), 32'h7);
    ready = 3'b000;
    repeat (2) @(negedge clk);
    check("release_led", 32'(led_o), 32'h0);

    press(1); press(1);
    @(negedge clk);
    check("cancel_led", 32'(led_o), 32'h0);
    check("cancel_state", 32'(state_o), 32'h0);

    press_all();
    @(negedge clk);
    check("count_state", 32'(state_o), 32'h1);
    check("count_num", 32'(num_o), 32'h3);
    for (int d = 3; d >= 0; d--) begin
      for (int c = 0; c < TD; c++) begin
        check("digit", 32'(num_o), 32'(d));
        @(negedge clk);
      end
    end
    check("play_state", 32'(state_o), 32'h2);
    check("play_go", 32'(go_o), 32'h1);
    @(negedge clk);
    check("go_pulse", 32'(go_o), 32'h0);

    ans(0, 1); ans_idle();
    check("hp_after_ok", 32'(hp_o), 32'h16);
    ans(0, 1); ans_idle();
    check("hp_elim", 32'(hp_o), 32'h02);
    check("res_state", 32'(state_o), 32'h3);
    check("res_winner", 32'(winner_o), 32'h0);
    check("res_wv", 32'(win_valid_o), 32'h1);
    check("res_led", 32'(led_o), 32'h1);

    press(2);
    check("back_state", 32'(state_o), 32'h0);
    check("back_hp", 32'(hp_o), 32'h2A);
    check("back_led", 32'(led_o), 32'h0);
    check("back_wv", 32'(win_valid_o), 32'h0);

    press_all();
    for (int c = 0; c < 20 && num_o != 4'd2; c++) @(negedge clk);
    check("reach_num2", 32'(num_o), 32'h2);
    press(0);
    check("abort_state", 32'(state_o), 32'h0);
    check("abort_num", 32'(num_o), 32'h0);
    check("abort_led", 32'(led_o), 32'h6);
    press(0);
    wait_state(2, 40);

    ans(0, 0); ans(1, 0); ans(2, 0); ans_idle();
    check("b2b_hp", 32'(hp_o), 32'h15);
    ans(1, 1); ans_idle();
    check("w1_state", 32'(state_o), 32'h3);
    check("w1_winner", 32'(winner_o), 32'h1);
    check("w1_led", 32'(led_o), 32'h2);

    press(0);
    ans(0, 0); ans_idle();
    check("lobby_ans_hp", 32'(hp_o), 32'h2A);
    press_all();
    wait_state(2, 40);
    ans(2, 0); ans(2, 0); ans(0, 0); ans(1, 0); ans_idle();
    check("setup_hp", 32'(hp_o), 32'h05);
    ans(2, 1); ans_idle();
    check("dead_ans_hp", 32'(hp_o), 32'h05);
    ans(3, 1); ans_idle();
    check("oor_ans_hp", 32'(hp_o), 32'h05);
    check("oor_state", 32'(state_o), 32'h2);
    ans(0, 0); ans_idle();
    check("w2_winner", 32'(winner_o), 32'h1);
    check("w2_draw", 32'(draw_o), 32'h0);

    press(1);
    press_all();
    repeat (3) @(negedge clk);
    check("pre_rst_state", 32'(state_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(state_o), 32'h0);
    check("rst_num", 32'(num_o), 32'h0);
    check("rst_led", 32'(led_o), 32'h0);
    check("rst_hp", 32'(hp_o), 32'h2A);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
